// File: rtl/lumped_amp_array_pkg.sv
// lumped_pkg: mode constants and the shared round/saturate helper for the lumped two-port array.
package lumped_pkg;
    localparam int MODE_AMP = 0;
    localparam int MODE_GYR = 1;

    // Rounds half toward +inf, then clamps to a signed w-bit range; sat flags the clamp.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] prod,
        input  int                 frac,
        input  int                 w,
        output logic               sat
    );
        logic signed [63:0] r_val;
        logic signed [63:0] r_hi;
        logic signed [63:0] r_lo;
        r_val = (prod + (64'sd1 <<< (frac - 1))) >>> frac;
        r_hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        r_lo  = -r_hi - 64'sd1;
        sat   = (r_val > r_hi) || (r_val < r_lo);
        return (r_val > r_hi) ? r_hi : (r_val < r_lo) ? r_lo : r_val;
    endfunction
endpackage

// File: rtl/lumped_amp_array_if.sv
// lumped_amp_array_if: valid/ready sample-vector stream into and out of the array.
interface lumped_amp_array_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [NCH*W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [NCH*W-1:0] out_data;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/lumped_amp_lane.sv
// lumped_amp_lane: one channel; S1 holds the full product, S2 holds the rounded/saturated sample.
module lumped_amp_lane
    import lumped_pkg::*;
#(
    parameter int W    = 16,
    parameter int GW   = 16,
    parameter int FRAC = 12,
    parameter bit NEG  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic signed [GW-1:0] i_gain,
    input  logic signed [W-1:0]  i_x,
    output logic signed [W-1:0]  o_y,
    output logic                 o_sat
);
    logic signed [W+GW-1:0] r_prod;
    logic signed [W-1:0]    w_y;
    logic                   w_sat;

    // Negation acts on the full product so -(min*min) cannot wrap before rounding.
    always_comb begin
        w_sat = 1'b0;
        w_y   = W'(round_sat(NEG ? -64'(r_prod) : 64'(r_prod), FRAC, W, w_sat));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
            o_y    <= '0;
            o_sat  <= 1'b0;
        end else if (i_en) begin
            r_prod <= (W+GW)'(i_gain) * (W+GW)'(i_x);
            o_y    <= w_y;
            o_sat  <= w_sat;
        end
    end
endmodule

// File: rtl/lumped_amp_array.sv
// lumped_amp_array: NCH-lane fixed-point amplifier / gyrator array with a gain file,
// sticky saturation flags and a two-stage valid/ready pipeline.
module lumped_amp_array
    import lumped_pkg::*;
#(
    parameter  int W        = 16,
    parameter  int GW       = 16,
    parameter  int FRAC     = 12,
    parameter  int NCH      = 4,
    parameter  int MODE     = MODE_AMP,
    parameter  int GAIN_RST = 4096,
    localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    lumped_amp_array_if.slave    bus,
    input  logic                 gain_we,
    input  logic [CW-1:0]        gain_ch,
    input  logic signed [GW-1:0] gain_data,
    input  logic                 sat_clr,
    output logic [NCH-1:0]       sat_flags,
    output logic [31:0]          sample_cnt
);
    logic                 w_en;
    logic                 w_fire;
    logic                 r_s1_valid;
    logic                 r_s2_valid;
    logic signed [GW-1:0] r_gain [NCH];
    logic [NCH-1:0]       w_sat;
    logic [NCH*W-1:0]     w_out;
    logic [NCH-1:0]       r_sat_flags;
    logic [31:0]          r_cnt;

    assign w_en          = !r_s2_valid || bus.out_ready;
    assign w_fire        = r_s2_valid && bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = w_out;
    assign sat_flags     = r_sat_flags;
    assign sample_cnt    = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_sat_flags <= '0;
            r_cnt       <= '0;
            for (int i = 0; i < NCH; i++) r_gain[i] <= GW'(GAIN_RST);
        end else begin
            if (w_en) begin
                r_s1_valid <= bus.in_valid;
                r_s2_valid <= r_s1_valid;
            end
            if (gain_we && 32'(gain_ch) < NCH) r_gain[gain_ch] <= gain_data;
            // A clamp on a delivered vector wins over a concurrent clear.
            r_sat_flags <= (sat_clr ? '0 : r_sat_flags) | (w_fire ? w_sat : '0);
            r_cnt       <= r_cnt + 32'(w_fire);
        end
    end

    // Gyrator pairs swap operands within each even/odd pair; the even lane is negated.
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        localparam int SRC = (MODE == MODE_GYR) ? (c ^ 1) : c;
        lumped_amp_lane #(
            .W   (W),
            .GW  (GW),
            .FRAC(FRAC),
            .NEG (MODE == MODE_GYR && (c % 2) == 0)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_en),
            .i_gain(r_gain[c]),
            .i_x   (bus.in_data[SRC*W +: W]),
            .o_y   (w_out[c*W +: W]),
            .o_sat (w_sat[c])
        );
    end
endmodule

// File: tb/tb_lumped_amp_array.sv
// tb_lumped_amp_array: directed and randomized checks of the amplifier (NCH=4) and
// gyrator (NCH=2) configurations against an arithmetic reference model.
module tb_lumped_amp_array;
    localparam int W = 16, GW = 16, FRAC = 12, NA = 4, NG = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lumped_amp_array_if #(.NCH(NA), .W(W)) a_bus ();
    lumped_amp_array_if #(.NCH(NG), .W(W)) g_bus ();

    logic        a_we, a_clr, g_we, g_clr;
    logic [1:0]  a_ch;
    logic [0:0]  g_ch;
    logic [15:0] a_gd, g_gd;
    logic [3:0]  a_flags;
    logic [1:0]  g_flags;
    logic [31:0] a_cnt, g_cnt;

    lumped_amp_array #(.W(W), .GW(GW), .FRAC(FRAC), .NCH(NA), .MODE(0), .GAIN_RST(4096)) u_amp (
        .clk(clk), .rst(rst), .bus(a_bus), .gain_we(a_we), .gain_ch(a_ch), .gain_data(a_gd),
        .sat_clr(a_clr), .sat_flags(a_flags), .sample_cnt(a_cnt)
    );
    lumped_amp_array #(.W(W), .GW(GW), .FRAC(FRAC), .NCH(NG), .MODE(1), .GAIN_RST(4096)) u_gyr (
        .clk(clk), .rst(rst), .bus(g_bus), .gain_we(g_we), .gain_ch(g_ch), .gain_data(g_gd),
        .sat_clr(g_clr), .sat_flags(g_flags), .sample_cnt(g_cnt)
    );

    typedef struct {
        logic [NA*W-1:0] d;
        logic [NA-1:0]   s;
    } exp_t;

    exp_t            q[$];
    int              m_gain[NA];
    logic [NA-1:0]   m_flags;
    int unsigned     m_cnt;
    int              checks = 0, fails = 0, n_acc = 0;
    bit              stall_prev;
    logic [NA*W-1:0] stall_data;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Exact rational result g*x/2^FRAC, rounded half up, then clamped.
    function automatic int amp(input int g, input int x, input bit neg, output bit s);
        longint p, t, r;
        p = longint'(g) * longint'(x);
        if (neg) p = -p;
        t = p + (64'sd1 << (FRAC - 1));
        r = (t >= 0) ? t / (64'sd1 << FRAC) : -((-t + (64'sd1 << FRAC) - 1) / (64'sd1 << FRAC));
        s = (r > 32767) || (r < -32768);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic int lane(input logic [63:0] v, input int c);
        return int'($signed(v[c*W +: W]));
    endfunction

    function automatic logic [63:0] vec4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        a_bus.in_valid = 1'b0; a_bus.out_ready = 1'b1; a_we = 1'b0; a_clr = 1'b0;
        g_bus.in_valid = 1'b0; g_bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        m_flags = '0;
        m_cnt = 0;
        stall_prev = 1'b0;
        for (int c = 0; c < NA; c++) m_gain[c] = 4096;
    endtask

    // One clock of the amplifier: drive, observe mid-cycle, update the model, advance.
    task automatic cyc(input bit v, input logic [63:0] d, input bit ordy, input bit we,
                       input logic [1:0] ch, input logic [15:0] gd, input bit clr);
        exp_t e, n;
        bit s, fire;
        a_bus.in_valid = v; a_bus.in_data = d; a_bus.out_ready = ordy;
        a_we = we; a_ch = ch; a_gd = gd; a_clr = clr;
        #4;
        chk("sat_flags", a_flags, m_flags);
        chk("sample_cnt", a_cnt, m_cnt);
        if (stall_prev) begin
            chk("stall_valid", a_bus.out_valid, 1);
            chk("stall_data", a_bus.out_data, stall_data);
        end
        if (a_bus.out_valid && !ordy) chk("stall_in_ready", a_bus.in_ready, 0);
        stall_prev = a_bus.out_valid && !ordy;
        stall_data = a_bus.out_data;
        fire = a_bus.out_valid && ordy;
        e.s = '0;
        if (fire) begin
            if (q.size() == 0) chk("spurious_out", a_bus.out_valid, 0);
            else begin
                e = q.pop_front();
                chk("out_data", a_bus.out_data, e.d);
            end
        end
        if (v && a_bus.in_ready) begin
            for (int c = 0; c < NA; c++) begin
                n.d[c*W +: W] = 16'(amp(m_gain[c], lane(d, c), 1'b0, s));
                n.s[c] = s;
            end
            q.push_back(n);
            n_acc++;
        end
        m_flags = (clr ? '0 : m_flags) | (fire ? e.s : '0);
        m_cnt += 32'(fire);
        if (we) m_gain[ch] = int'($signed(gd));
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] gd32;
        bit          s;
        g_bus.in_data = '0; g_we = 1'b0; g_ch = '0; g_gd = '0; g_clr = 1'b0;
        a_bus.in_data = '0; a_ch = '0; a_gd = '0;
        do_reset();
        chk("rst_out_valid", a_bus.out_valid, 0);
        chk("rst_out_data", a_bus.out_data, 0);
        chk("rst_flags", a_flags, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_in_ready", a_bus.in_ready, 1);

        // Gain 2.0 on ch0, latency of two cycles.
        cyc(0, 0, 1, 1, 0, 16'd8192, 0);
        cyc(1, vec4(1000, -3, 0, 0), 1, 0, 0, 0, 0);
        chk("lat_t1_valid", a_bus.out_valid, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("lat_t2_valid", a_bus.out_valid, 1);
        chk("amp_ch0", lane(a_bus.out_data, 0), 2000);
        chk("amp_ch1", lane(a_bus.out_data, 1), -3);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("amp_flags", a_flags, 0);

        // Saturation, stickiness, clear racing a new clamp.
        cyc(0, 0, 1, 1, 2, 16'd8192, 0);
        cyc(1, vec4(0, 0, 20000, 0), 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("sat_ch2", lane(a_bus.out_data, 2), 32767);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("sat_flag_set", a_flags[2], 1);
        repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
        chk("sat_flag_sticky", a_flags[2], 1);
        cyc(1, vec4(0, 0, 20000, 0), 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1);
        chk("sat_clr_vs_set", a_flags[2], 1);
        cyc(0, 0, 1, 0, 0, 0, 1);
        chk("sat_clr", a_flags, 0);

        // Rounding at gain 0.5.
        cyc(0, 0, 1, 1, 3, 16'd2048, 0);
        cyc(1, vec4(0, 0, 0, 3), 1, 0, 0, 0, 0);
        cyc(1, vec4(0, 0, 0, -3), 1, 0, 0, 0, 0);
        chk("round_pos", lane(a_bus.out_data, 3), 2);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("round_neg", lane(a_bus.out_data, 3), -1);
        repeat (2) cyc(0, 0, 1, 0, 0, 0, 0);

        // Backpressure: five vectors with out_ready pattern 1,0,0,1.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 40 && (n_acc < 5 || q.size() > 0 || a_bus.out_valid); i++) begin
            bit r;
            r = (i % 4 == 0) || (i % 4 == 3) || (n_acc >= 5);
            cyc(n_acc < 5, {$urandom, $urandom}, r, 0, 0, 0, 0);
        end
        chk("bp_accepted", n_acc, 5);
        chk("bp_cnt", a_cnt, 5);

        // Reset mid-stream drops everything in flight.
        cyc(1, {$urandom, $urandom}, 1, 0, 0, 0, 0);
        cyc(1, {$urandom, $urandom}, 1, 0, 0, 0, 0);
        do_reset();
        chk("midrst_valid", a_bus.out_valid, 0);
        chk("midrst_cnt", a_cnt, 0);
        repeat (4) cyc(0, 0, 1, 0, 0, 0, 0);
        chk("midrst_quiet_cnt", a_cnt, 0);

        // Gain write racing an accept uses the old gain.
        cyc(1, vec4(10, 0, 0, 0), 1, 1, 0, 16'd8192, 0);
        cyc(1, vec4(10, 0, 0, 0), 1, 0, 0, 0, 0);
        chk("race_old_gain", lane(a_bus.out_data, 0), 10);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("race_new_gain", lane(a_bus.out_data, 0), 20);

        // Randomized traffic, stalls, gain writes and clears.
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 16'($urandom),
                $urandom_range(0, 15) == 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        chk("drain_empty", q.size(), 0);

        // Gyrator pair with unity gains.
        g_bus.in_valid = 1'b1; g_bus.in_data = {16'sd200, 16'sd100};
        @(posedge clk); #1;
        g_bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("gyr_valid", g_bus.out_valid, 1);
        chk("gyr_out0", lane(64'(g_bus.out_data), 0), -200);
        chk("gyr_out1", lane(64'(g_bus.out_data), 1), 100);
        @(posedge clk); #1;
        g_bus.in_valid = 1'b1; g_bus.in_data = {16'h8000, 16'h0000};
        @(posedge clk); #1;
        g_bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("gyr_sat_out0", lane(64'(g_bus.out_data), 0), 32767);
        chk("gyr_sat_out1", lane(64'(g_bus.out_data), 1), 0);
        @(posedge clk); #1;
        chk("gyr_sat_flag", g_flags, 2'b01);
        chk("gyr_cnt", g_cnt, 2);
        for (int i = 0; i < 16; i++) begin
            gd32 = $urandom;
            g_bus.in_valid = 1'b1; g_bus.in_data = gd32;
            @(posedge clk); #1;
            g_bus.in_valid = 1'b0;
            @(posedge clk); #1;
            chk("gyr_rand0", lane(64'(g_bus.out_data), 0), amp(4096, lane(64'(gd32), 1), 1'b1, s));
            chk("gyr_rand1", lane(64'(g_bus.out_data), 1), amp(4096, lane(64'(gd32), 0), 1'b0, s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/lumped_amp_array.md
Name: lumped_amp_array

Overview:
- Sampled, multi-channel, fixed-point model of the lumped two-port family (amplifier, gyrator).
- Generalises the single ideal-gain amplifier to NCH channels with per-channel programmable gain, round and saturate, and a valid/ready pipeline.
- MODE selects independent amplifiers or cross-coupled gyrator pairs.
- Sits between the discrete-time stimulus source and the digital port of mixed-signal benches.

Parameters:
- W, 16, signed sample width per channel
- GW, 16, signed gain width per channel
- FRAC, 12, fractional bits of gain (1.0 = 1<<FRAC); FRAC >= 1
- NCH, 4, channel count; must be even when MODE=1
- MODE, 0, 0 = independent amplifiers, 1 = gyrator pairs
- GAIN_RST, 4096, reset value of every gain register

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input sample vector valid
- in_ready  out  1  block accepts the vector this cycle
- in_data  in  NCH*W  channel c at bits [c*W +: W], signed
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts
- out_data  out  NCH*W  same packing as in_data
- gain_we  in  1  gain write strobe
- gain_ch  in  max(1,clog2(NCH))  channel to write
- gain_data  in  GW  new gain, signed
- sat_clr  in  1  clear all saturation flags
- sat_flags  out  NCH  sticky per-channel saturation flags
- sample_cnt  out  32  count of vectors delivered (out_valid && out_ready)

Behaviour:
- Reset: one clock, synchronous, active-high. Port names clk and rst.
- Reset values: out_valid=0, out_data=0, sat_flags=0, sample_cnt=0, all gains=GAIN_RST. in_ready=1 during the cycle after reset.
- Reset mid-operation drops all in-flight vectors. No output follows.
- Pipeline has 2 stages: S1 registers operands and the product, S2 rounds and saturates.
- Enable en = !s2_valid || out_ready. Both stages advance only when en is high. in_ready = en.
- Latency: a vector accepted at cycle t appears with out_valid at t+2 when out_ready has been held high.
- Stall: while out_valid && !out_ready, out_data and out_valid hold stable and no input is accepted.
- Operand selection:
  - MODE=0: lane c computes g[c]*x[c].
  - MODE=1, lane 2k: -(g[2k]*x[2k+1]).
  - MODE=1, lane 2k+1: g[2k+1]*x[2k].
- Arithmetic:
  - The product is a full W+GW signed value. Negation is applied to the product before rounding.
  - Add 1<<(FRAC-1), then arithmetic shift right by FRAC.
  - Clamp to [-(2^(W-1)), 2^(W-1)-1].
  - A clamp sets sat_flags[c] when that vector leaves S2 with en high.
- Gain writes:
  - A write with gain_we takes effect on the following cycle.
  - A vector accepted in the same cycle as a write uses the old gain.
  - A gain_ch value >= NCH is ignored.
- Writes and stalls: gain writes are allowed during stalls. Vectors already in S1 keep their captured gain.
- sat_clr and a new saturation in the same cycle: the flag ends set (set wins).
- sample_cnt wraps from 2^32-1 to 0.

Decomposition:
- Package lumped_pkg:
  - MODE_AMP=0 and MODE_GYR=1 constants.
  - Pure function round_sat(product, FRAC, W) returning the value and a sat bit.
- Sub-module lumped_amp_lane, instantiated NCH times: one lane's operand register, multiply, round and saturate.
- Top level owns the handshake, gain register file, cross-coupling mux, flags and counter.

Test Plan:
- Amp mode, defaults. Write gain ch0=8192 (2.0). in ch0=1000, ch1=-3 -> out ch0=2000, ch1=-3, out_valid 2 cycles after accept, sat_flags=0.
- Saturation: gain ch2=8192, in ch2=20000 -> out ch2=32767 and sat_flags[2]=1. Flag persists until sat_clr. sat_clr concurrent with a new clamp keeps it 1.
- Rounding: gain=2048 (0.5). in=3 -> 2 (1.5 rounds up). in=-3 -> -1 (-1.5 rounds toward +inf).
- Gyrator (MODE=1, NCH=2, gains 4096): in0=100, in1=200 -> out0=-200, out1=100. in1=-32768 -> out0=32767 with sat_flags[0]=1.
- Backpressure: stream 5 vectors with out_ready toggling 1,0,0,1,... -> no loss or duplication, out_data stable during stalls, sample_cnt=5. Assert rst mid-stream -> out_valid=0 next cycle and sample_cnt=0.
- Gain-write race: write ch0=8192 in the same cycle a vector with in0=10 is accepted -> out0=10. Next vector with in0=10 -> 20.
